// File: rtl/mlp_layer_engine.sv
// -----------------------------------------------------------------------------
// mlp_layer_engine
//   Chained fully-connected layer engine (y = sat(round(W * x)) per layer).
//   An input vector is loaded once. Then NUM_LAYERS square weight matrices are
//   streamed in, and the final vector is drained on the result stream.
//   Two activation buffers are used as ping-pong buffers: the active buffer
//   feeds the multipliers, and results go to the shadow buffer.
//
// Optional feature:
//   MLP_RELU_EN - when defined, negative results of every layer except the
//                 last are clamped to zero.
//
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   start_i          start a run (only honoured while idle)
//   in_valid_i       load stream valid
//   in_ready_o       load stream ready (LOAD_IN / COMPUTE only)
//   in_data_i        load beat: {x[2k+1], x[2k]} or {W[2p+1][c], W[2p][c]}
//   out_valid_o      result stream valid
//   out_ready_i      result stream ready
//   out_data_o       result beat {y[2k+1], y[2k]}
//   busy_o           high from accepted start until done
//   done_o           pulse on the final result handshake
// -----------------------------------------------------------------------------
module mlp_layer_engine #(
    parameter int DIM        = 16,
    parameter int DATA_W     = 16,
    parameter int NUM_LAYERS = 8,
    parameter int FRAC       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*DATA_W-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2*DATA_W-1:0] out_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int PAIRS  = DIM / 2;
    localparam int CW     = $clog2(DIM);
    localparam int PW     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int LW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int ACC_W  = 2 * DATA_W + CW + 1;
    localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic [CW-1:0] COL_LAST   = CW'(DIM - 1);
    localparam logic [PW-1:0] PAIR_LAST  = PW'(PAIRS - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);

    localparam logic signed [ACC_W-1:0] RND     = (FRAC > 0) ? (ACC_W'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD_IN, COMPUTE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] buf_a [DIM];
    logic [DATA_W-1:0] buf_b [DIM];
    logic              sel;            // 0: buf_a is active, 1: buf_b is active

    logic [PW-1:0] load_k, pair, drain_k;
    logic [CW-1:0] col;
    logic [LW-1:0] layer;
    logic signed [ACC_W-1:0] acc0, acc1;

    logic in_fire, load_fire, w_fire, row_done, layer_done, run_done;
    logic out_fire, drain_last;

    logic signed [DATA_W-1:0]   w_lo, w_hi, x_c;
    logic signed [2*DATA_W-1:0] prod0, prod1;
    logic signed [ACC_W-1:0]    sum0, sum1;
    logic [DATA_W-1:0]          pp0, pp1, y0, y1;

    logic          res_sel;
    logic [CW-1:0] res_idx;
    logic [DATA_W-1:0] res_lo, res_hi;

    function automatic logic [DATA_W-1:0] post_proc(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = (s + RND) >>> FRAC;
        if (r > SAT_MAX)
            r = SAT_MAX;
        else if (r < SAT_MIN)
            r = SAT_MIN;
        return DATA_W'(r);
    endfunction

    // Handshakes and end-of-block conditions
    assign in_ready_o = (state == LOAD_IN) || (state == COMPUTE);
    assign busy_o     = (state != IDLE);
    assign in_fire    = in_valid_i && in_ready_o;
    assign load_fire  = in_fire && (state == LOAD_IN);
    assign w_fire     = in_fire && (state == COMPUTE);
    assign row_done   = w_fire && (col == COL_LAST);
    assign layer_done = row_done && (pair == PAIR_LAST);
    assign run_done   = layer_done && (layer == LAYER_LAST);
    assign out_fire   = out_valid_o && out_ready_i;
    assign drain_last = (drain_k == PAIR_LAST);
    assign done_o     = (state == DRAIN) && out_fire && drain_last;

    // Multiply-accumulate for the current weight beat
    assign w_lo  = in_data_i[DATA_W-1:0];
    assign w_hi  = in_data_i[2*DATA_W-1:DATA_W];
    assign x_c   = sel ? buf_b[col] : buf_a[col];
    assign prod0 = (2*DATA_W)'(w_lo) * (2*DATA_W)'(x_c);
    assign prod1 = (2*DATA_W)'(w_hi) * (2*DATA_W)'(x_c);
    assign sum0  = acc0 + ACC_W'(prod0);
    assign sum1  = acc1 + ACC_W'(prod1);
    assign pp0   = post_proc(sum0);
    assign pp1   = post_proc(sum1);

`ifdef MLP_RELU_EN
    logic relu_now;
    assign relu_now = (layer != LAYER_LAST);
    assign y0 = (relu_now && pp0[DATA_W-1]) ? '0 : pp0;
    assign y1 = (relu_now && pp1[DATA_W-1]) ? '0 : pp1;
`else
    assign y0 = pp0;
    assign y1 = pp1;
`endif

    // Result readout. The first drain beat is loaded on the last weight beat,
    // before the buffer swap takes effect, so the result buffer is the shadow
    // buffer then and the active buffer once in DRAIN.
    assign res_sel = (state == DRAIN) ? sel : ~sel;
    assign res_idx = (state == DRAIN) ? {drain_k + PW'(1), 1'b0} : '0;
    assign res_lo  = res_sel ? buf_b[res_idx]         : buf_a[res_idx];
    assign res_hi  = res_sel ? buf_b[res_idx + CW'(1)] : buf_a[res_idx + CW'(1)];

    // FSM
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = LOAD_IN;
            LOAD_IN: if (load_fire && (load_k == PAIR_LAST)) state_nxt = COMPUTE;
            COMPUTE: if (run_done) state_nxt = DRAIN;
            DRAIN:   if (out_fire && drain_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, accumulators and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_k      <= '0;
            pair        <= '0;
            drain_k     <= '0;
            col         <= '0;
            layer       <= '0;
            acc0        <= '0;
            acc1        <= '0;
            sel         <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        load_k <= '0;
                        pair   <= '0;
                        col    <= '0;
                        layer  <= '0;
                        acc0   <= '0;
                        acc1   <= '0;
                    end
                end
                LOAD_IN: begin
                    if (load_fire)
                        load_k <= load_k + PW'(1);
                end
                COMPUTE: begin
                    if (w_fire) begin
                        if (col == COL_LAST) begin
                            acc0 <= '0;
                            acc1 <= '0;
                            col  <= '0;
                            if (pair == PAIR_LAST) begin
                                pair  <= '0;
                                sel   <= ~sel;
                                layer <= layer + LW'(1);
                                if (layer == LAYER_LAST) begin
                                    out_valid_o <= 1'b1;
                                    out_data_o  <= {res_hi, res_lo};
                                    drain_k     <= '0;
                                end
                            end else begin
                                pair <= pair + PW'(1);
                            end
                        end else begin
                            acc0 <= sum0;
                            acc1 <= sum1;
                            col  <= col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (drain_last) begin
                            out_valid_o <= 1'b0;
                        end else begin
                            drain_k    <= drain_k + PW'(1);
                            out_data_o <= {res_hi, res_lo};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Activation buffers (not reset; every run overwrites them before use)
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load_fire) begin
                if (sel) begin
                    buf_b[{load_k, 1'b0}] <= in_data_i[DATA_W-1:0];
                    buf_b[{load_k, 1'b1}] <= in_data_i[2*DATA_W-1:DATA_W];
                end else begin
                    buf_a[{load_k, 1'b0}] <= in_data_i[DATA_W-1:0];
                    buf_a[{load_k, 1'b1}] <= in_data_i[2*DATA_W-1:DATA_W];
                end
            end
            if (row_done) begin
                if (sel) begin
                    buf_a[{pair, 1'b0}] <= y0;
                    buf_a[{pair, 1'b1}] <= y1;
                end else begin
                    buf_b[{pair, 1'b0}] <= y0;
                    buf_b[{pair, 1'b1}] <= y1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// -----------------------------------------------------------------------------
// tb_mlp_layer_engine
//   Directed, table-driven bench for mlp_layer_engine with DIM=4, DATA_W=16,
//   FRAC=8 and NUM_LAYERS=2. Expected results are hand-computed. The
//   MLP_RELU_EN macro selects the matching expectations.
// -----------------------------------------------------------------------------
module tb_mlp_layer_engine;

    localparam int DIM = 4;
    localparam int DW  = 16;
    localparam int NL  = 2;
    localparam int FR  = 8;

    typedef logic [3:0][3:0][15:0] w_t;   // [row][col]

    typedef struct {
        logic [3:0][15:0] x;
        w_t               w1;
        w_t               w2;
        logic [31:0]      e0;
        logic [31:0]      e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic        busy_o;
    logic        done_o;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    mlp_layer_engine #(.DIM(DIM), .DATA_W(DW), .NUM_LAYERS(NL), .FRAC(FR)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_o) done_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out, got no handshake expected one", nm);
    endtask

    function automatic w_t diag(input logic [15:0] d);
        w_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = d;
        return m;
    endfunction

    function automatic vec_t mk(input logic [15:0] x0, x1, x2, x3,
                                input w_t w1, w2, input logic [31:0] e0, e1);
        vec_t v;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.w1 = w1; v.w2 = w2; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    // Entered and left on a falling edge.
    task automatic send_beat(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        for (int t = 0; t < 50; t++) begin
            if (in_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("in_ready");
        else @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic send_layer(input w_t w);
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++)
                send_beat({w[2*p+1][c], w[2*p][c]});
    endtask

    task automatic do_start();
        // Junk on the load stream while idle must not be consumed.
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic run(input vec_t v, input bit glitch, input int bp,
                       output logic [31:0] b0, output logic [31:0] b1);
        bit ok;
        int dstart;
        logic [31:0] d;
        b0 = '0;
        b1 = '0;
        dstart = done_cnt;
        do_start();
        send_beat({v.x[1], v.x[0]});
        send_beat({v.x[3], v.x[2]});
        if (glitch) start_i = 1'b1;
        send_layer(v.w1);
        start_i = 1'b0;
        send_layer(v.w2);
        check("first_valid_latency", {31'd0, out_valid_o}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (out_valid_o) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) timeout("out_valid");
            d = out_data_o;
            if (k == 0 && bp > 0) begin
                out_ready_i = 1'b0;
                repeat (bp) begin
                    @(negedge clk);
                    check("bp_valid", {31'd0, out_valid_o}, 32'd1);
                    check("bp_data_stable", out_data_o, d);
                    check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
                end
            end
            out_ready_i = 1'b1;
            #1;
            check("done_pulse", {31'd0, done_o}, (k == 1) ? 32'd1 : 32'd0);
            if (k == 0) b0 = out_data_o;
            else        b1 = out_data_o;
            @(posedge clk);
            @(negedge clk);
            out_ready_i = 1'b0;
        end
        check("valid_after_done", {31'd0, out_valid_o}, 32'd0);
        check("busy_after_done", {31'd0, busy_o}, 32'd0);
        check("done_count", done_cnt - dstart, 32'd1);
    endtask

    vec_t vecs[6];
    vec_t id_v;
    w_t wc;
    logic [31:0] r0, r1;

    initial begin
        wc = '0;
        wc[0][0] = 16'h0180; wc[0][1] = 16'h0100;
        wc[1][2] = 16'h0200;
        wc[2][0] = 16'hFF00;
        wc[3][1] = 16'h0080;

        vecs[0] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, diag(16'h0100), diag(16'h0100),
                     32'h0200_0100, 32'h0400_0300);
        vecs[1] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, {16{16'h7FFF}}, {16{16'h7FFF}},
                     32'h7FFF_7FFF, 32'h7FFF_7FFF);
`ifdef MLP_RELU_EN
        vecs[2] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, diag(16'hFF00), diag(16'h0100),
                     32'h0000_0000, 32'h0000_0000);
        vecs[3] = mk(16'h0100, 16'hFF80, 16'h0040, 16'h0000, wc, diag(16'h0100),
                     32'h0080_0100, 32'h0000_0000);
        vecs[4] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, diag(16'h8000), diag(16'h0100),
                     32'h0000_0000, 32'h0000_0000);
`else
        vecs[2] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, diag(16'hFF00), diag(16'h0100),
                     32'hFE00_FF00, 32'hFC00_FD00);
        vecs[3] = mk(16'h0100, 16'hFF80, 16'h0040, 16'h0000, wc, diag(16'h0100),
                     32'h0080_0100, 32'hFFC0_FF00);
        vecs[4] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, diag(16'h8000), diag(16'h0100),
                     32'h8000_8000, 32'h8000_8000);
`endif
        // Negative results of the last layer are never clamped.
        vecs[5] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, diag(16'h0100), diag(16'hFF00),
                     32'hFE00_FF00, 32'hFC00_FD00);
        id_v = vecs[0];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_out_data", out_data_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run(vecs[i], 1'b0, 0, r0, r1);
            check($sformatf("vec%0d_beat0", i), r0, vecs[i].e0);
            check($sformatf("vec%0d_beat1", i), r1, vecs[i].e1);
        end

        // Backpressure on the first result beat
        run(id_v, 1'b0, 5, r0, r1);
        check("bp_beat0", r0, id_v.e0);
        check("bp_beat1", r1, id_v.e1);

        // start_i held during the first layer's weights
        run(id_v, 1'b1, 0, r0, r1);
        check("glitch_beat0", r0, id_v.e0);
        check("glitch_beat1", r1, id_v.e1);

        // Reset in the middle of COMPUTE
        do_start();
        send_beat({id_v.x[1], id_v.x[0]});
        send_beat({id_v.x[3], id_v.x[2]});
        send_beat(32'h1234_5678);
        send_beat(32'h0BAD_F00D);
        send_beat(32'h7FFF_8000);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("midrst_out_data", out_data_o, 32'd0);
        run(id_v, 1'b0, 0, r0, r1);
        check("midrst_beat0", r0, id_v.e0);
        check("midrst_beat1", r1, id_v.e1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mlp_layer_engine.md
MLP_LAYER_ENGINE -- requirements
Module: mlp_layer_engine

Interface
REQ-001 SHALL have parameter DIM, default 16, meaning vector length and square weight-matrix size (even, >=4).
REQ-002 SHALL have parameter DATA_W, default 16, meaning signed fixed-point element width.
REQ-003 SHALL have parameter NUM_LAYERS, default 8, meaning number of chained layers computed per run (>=1).
REQ-004 SHALL have parameter FRAC, default 8, meaning fractional bits of all operands.
REQ-005 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start_i  input  1  starts a run when the engine is idle.
REQ-008 SHALL have ports in_valid_i input 1, in_ready_o output 1, in_data_i input 2*DATA_W; these form the load stream carrying inputs, then weights.
REQ-009 SHALL have ports out_valid_o output 1, out_ready_i input 1, out_data_o output 2*DATA_W; these form the result stream.
REQ-010 SHALL have port busy_o  output  1  high from the accepted start until done.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse on the final result handshake.

Function
REQ-012 SHALL implement an FSM with states IDLE, LOAD_IN, COMPUTE and DRAIN; start_i in IDLE goes to LOAD_IN next cycle, and start_i is ignored in all other states.
REQ-013 SHALL transfer a load beat only when in_valid_i and in_ready_o are both high; in_ready_o SHALL be 1 only in LOAD_IN and COMPUTE.
REQ-014 SHALL, in LOAD_IN, accept DIM/2 beats, where beat k is {x[2k+1], x[2k]}, into the active activation buffer, then enter COMPUTE.
REQ-015 SHALL, in COMPUTE, take per layer DIM*DIM/2 weight beats ordered row-pair p outer and column c inner, where a beat is {W[2p+1][c], W[2p][c]}.
REQ-016 SHALL, on each accepted weight beat, multiply both weights by x[c] (signed, full precision) and add into two accumulators wide enough that no overflow occurs for DIM terms.
REQ-017 SHALL, on beat c==DIM-1, form the final sums including that beat, post-process them, write y[2p] and y[2p+1] to the shadow buffer in the same cycle, and clear the accumulators, with no bubble cycle.
REQ-018 SHALL post-process by adding 2^(FRAC-1) (only if FRAC>0), arithmetic-shifting right by FRAC, and saturating to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 SHALL, at the end of a layer, swap the active and shadow buffers (ping-pong); after NUM_LAYERS layers it SHALL enter DRAIN.
REQ-020 SHALL, in DRAIN, emit DIM/2 registered beats {y[2k+1], y[2k]}, k ascending; the first out_valid_o rises the cycle after the last weight beat is accepted.
REQ-021 SHALL hold out_data_o stable and out_valid_o high while out_ready_i is low (backpressure), and SHALL advance only on a handshake.
REQ-022 SHALL, on the last DRAIN handshake, pulse done_o, drop busy_o and out_valid_o next cycle, and return to IDLE.
REQ-023 SHALL ignore in_valid_i while in_ready_o is low; such data SHALL NOT be consumed.

Reset
REQ-024 SHALL, on rst_n low at any state including mid-run, enter IDLE and drive in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0 and done_o=0, and clear all counters and accumulators.
REQ-025 SHALL NOT be required to clear the activation buffers on reset; a new run SHALL overwrite them fully before use.

Configuration
REQ-026 SHALL, with macro MLP_RELU_EN defined, clamp negative post-processed results to 0 for every layer except the last.
REQ-027 SHALL, without MLP_RELU_EN, pass post-processed results unchanged, and SHALL NOT instantiate the clamp logic.

Verification (DIM=4, DATA_W=16, FRAC=8, NUM_LAYERS=2)
REQ-028 SHALL cover identity: x=[0x0100,0x0200,0x0300,0x0400] with diagonal 0x0100 weights in both layers -> out beats 0x02000100 then 0x04000300, with done_o pulsed once.
REQ-029 SHALL cover saturation: all x=0x7FFF and all weights 0x7FFF -> both out beats 0x7FFF7FFF.
REQ-030 SHALL cover ReLU: layer-1 diagonal 0xFF00, layer-2 identity, x as in REQ-028 -> with MLP_RELU_EN both beats 0x00000000; without it 0xFE00FF00 then 0xFC00FD00.
REQ-031 SHALL cover backpressure: out_ready_i held low 5 cycles at the first result -> out_valid_o stays 1, out_data_o stays stable, in_ready_o stays 0, and no beat is lost.
REQ-032 SHALL cover reset mid-COMPUTE: rst_n low 1 cycle -> busy_o=0, in_ready_o=0 and out_valid_o=0 next cycle; a following run then reproduces the REQ-028 results.
REQ-033 SHALL cover start_i pulsed during COMPUTE -> no effect on state, counters or results.
